// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states
// and operand signedness decoding.
package rv32m_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   function automatic logic a_is_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic b_is_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/rv32m_muldiv_unit_if.sv
// Request/response bundle between the issue stage, the muldiv unit and the
// register file write port.
interface rv32m_muldiv_unit_if #(parameter int XLEN = 32);
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      write_select;
   logic            WR_EN;

   modport master (output start, flush, funct3, op_a, op_b, rd,
                   input  busy, done, result, write_select, WR_EN);
   modport slave  (input  start, flush, funct3, op_a, op_b, rd,
                   output busy, done, result, write_select, WR_EN);
endinterface

// File: rtl/rv32m_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, trial-subtract the divisor and keep the result if it did not borrow.
module rv32m_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);
   logic [XLEN:0] shifted_s;
   logic [XLEN:0] diff_s;

   // Trial subtract; bit XLEN of the difference is the borrow.
   always_comb begin
      shifted_s = {rem_in, quo_in[XLEN-1]};
      diff_s    = shifted_s - {1'b0, divisor};
      if (!diff_s[XLEN]) begin
         rem_out = diff_s[XLEN-1:0];
         quo_out = {quo_in[XLEN-2:0], 1'b1};
      end else begin
         rem_out = shifted_s[XLEN-1:0];
         quo_out = {quo_in[XLEN-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed XLEN+2 cycle latency; outputs
// are registered so they are stable across the register file's negedge write.
module rv32m_muldiv_unit
   import rv32m_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic             clock,
   input  logic             RESET_N,
   rv32m_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   state_e            state_r;
   funct3_e           f3_r;
   logic [CW-1:0]     cnt_r;
   logic [4:0]        rd_r;
   logic [XLEN-1:0]   mag_a_r, mag_b_r, final_r;
   logic [2*XLEN-1:0] acc_r;
   logic              sa_r, sb_r, zero_r, ovf_r;
   logic              busy_r, done_r, wr_en_r;
   logic [XLEN-1:0]   result_r;
   logic [4:0]        wsel_r;

   logic              sa_s, sb_s, zero_s, ovf_s;
   logic [XLEN-1:0]   mag_a_s, mag_b_s;
   logic [XLEN:0]     add_s;
   logic [2*XLEN-1:0] mul_next_s, prod_s;
   logic [XLEN-1:0]   rem_next_s, quo_next_s, quo_s, rem_s, fix_s;

   // Decode operand signs, magnitudes and special cases at request time.
   always_comb begin
      sa_s    = a_is_signed(bus.funct3) & bus.op_a[XLEN-1];
      sb_s    = b_is_signed(bus.funct3) & bus.op_b[XLEN-1];
      mag_a_s = sa_s ? -bus.op_a : bus.op_a;
      mag_b_s = sb_s ? -bus.op_b : bus.op_b;
      zero_s  = ~|bus.op_b;
      ovf_s   = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.op_b);
   end

   // Shift-add multiply: product accumulates in the top half while the
   // multiplier bits drain out of the bottom half.
   always_comb begin
      add_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                   (acc_r[0] ? {1'b0, mag_a_r} : {(XLEN+1){1'b0}});
      mul_next_s = {add_s, acc_r[XLEN-1:1]};
   end

   rv32m_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in  (acc_r[2*XLEN-1:XLEN]),
      .quo_in  (acc_r[XLEN-1:0]),
      .divisor (mag_b_r),
      .rem_out (rem_next_s),
      .quo_out (quo_next_s)
   );

   // Sign restoration and result selection. A zero divisor leaves the quotient
   // all ones and the remainder equal to |op_a|, so REM by zero needs no override.
   always_comb begin
      prod_s = (sa_r ^ sb_r) ? -acc_r : acc_r;
      quo_s  = (sa_r ^ sb_r) ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      rem_s  = sa_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      case (f3_r)
         F3_MUL:                       fix_s = prod_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fix_s = prod_s[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU: begin
            if (zero_r)     fix_s = {XLEN{1'b1}};
            else if (ovf_r) fix_s = {1'b1, {(XLEN-1){1'b0}}};
            else            fix_s = quo_s;
         end
         F3_REM, F3_REMU:              fix_s = ovf_r ? {XLEN{1'b0}} : rem_s;
         default:                      fix_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM, iteration counter, datapath and registered outputs.
   always_ff @(posedge clock or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r  <= S_IDLE;
         f3_r     <= F3_MUL;
         cnt_r    <= {CW{1'b0}};
         rd_r     <= 5'd0;
         mag_a_r  <= {XLEN{1'b0}};
         mag_b_r  <= {XLEN{1'b0}};
         final_r  <= {XLEN{1'b0}};
         acc_r    <= {(2*XLEN){1'b0}};
         sa_r     <= 1'b0;
         sb_r     <= 1'b0;
         zero_r   <= 1'b0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         wr_en_r  <= 1'b0;
         result_r <= {XLEN{1'b0}};
         wsel_r   <= 5'd0;
      end else begin
         done_r  <= 1'b0;
         wr_en_r <= 1'b0;
         if ((state_r != S_IDLE) && bus.flush) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               S_IDLE: begin
                  if (bus.start) begin
                     f3_r    <= funct3_e'(bus.funct3);
                     rd_r    <= bus.rd;
                     mag_a_r <= mag_a_s;
                     mag_b_r <= mag_b_s;
                     sa_r    <= sa_s;
                     sb_r    <= sb_s;
                     zero_r  <= zero_s;
                     ovf_r   <= ovf_s;
                     acc_r   <= bus.funct3[2] ? {{XLEN{1'b0}}, mag_a_s}
                                              : {{XLEN{1'b0}}, mag_b_s};
                     cnt_r   <= CW'(XLEN-1);
                     busy_r  <= 1'b1;
                     state_r <= S_CALC;
                  end
               end
               S_CALC: begin
                  acc_r <= f3_r[2] ? {rem_next_s, quo_next_s} : mul_next_s;
                  if (cnt_r == {CW{1'b0}}) state_r <= S_FIXUP;
                  else                     cnt_r   <= cnt_r - CW'(1);
               end
               S_FIXUP: begin
                  final_r <= fix_s;
                  state_r <= S_DONE;
               end
               S_DONE: begin
                  result_r <= final_r;
                  wsel_r   <= rd_r;
                  done_r   <= 1'b1;
                  wr_en_r  <= (rd_r != 5'd0);
                  busy_r   <= 1'b0;
                  state_r  <= S_IDLE;
               end
               default: begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.result       = result_r;
   assign bus.write_select = wsel_r;
   assign bus.WR_EN        = wr_en_r;
endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed vectors push expectations,
// a negedge monitor pops and checks every done pulse, including its latency.
module tb_rv32m_muldiv_unit;
   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] res;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  ws;
      logic        we;
      int          start_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   exp_t q[$];

   rv32m_muldiv_unit_if #(.XLEN(32)) bus ();

   rv32m_muldiv_unit dut (
      .clock   (clk),
      .RESET_N (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   vec_t vecs [13] = '{
      '{3'b000, 32'd7,        32'd6,        5'd5,  32'h0000002A},
      '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000},
      '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE},
      '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF},
      '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD},
      '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF},
      '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14},
      '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2},
      '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000},
      '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000},
      '{3'b000, 32'h12345678, 32'h00000010, 5'd12, 32'h23456780},
      '{3'b100, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF},
      '{3'b111, 32'd5,        32'd0,        5'd31, 32'd5}
   };

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            e = q.pop_front();
            check("result", bus.result, e.res);
            check("write_select", {27'd0, bus.write_select}, {27'd0, e.ws});
            check("WR_EN", {31'd0, bus.WR_EN}, {31'd0, e.we});
            check("latency", 32'(cyc - e.start_cyc), 32'd34);
         end
         done_cnt++;
      end
   end

   // Called at a negedge: present a request for one cycle.
   task automatic issue(input vec_t v, input bit push);
      exp_t e;
      bus.funct3 = v.f3;
      bus.op_a   = v.a;
      bus.op_b   = v.b;
      bus.rd     = v.rd;
      bus.start  = 1'b1;
      if (push) begin
         e.res = v.res;
         e.ws = v.rd;
         e.we = (v.rd != 5'd0);
         e.start_cyc = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int prev);
      int t;
      t = 0;
      while (done_cnt == prev && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt == prev) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected one", t);
      end
   endtask

   task automatic run_op(input vec_t v);
      int prev;
      @(negedge clk);
      prev = done_cnt;
      issue(v, 1'b1);
      wait_done(prev);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      exp_t e;
      int prev;
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
      bus.op_a = 32'd0; bus.op_b = 32'd0; bus.rd = 5'd0;

      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      check("reset_result", bus.result, 32'd0);
      check("reset_wsel", {27'd0, bus.write_select}, 32'd0);
      check("reset_wr_en", {31'd0, bus.WR_EN}, 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i]);

      // Flush mid-CALC: the op dies silently and the last result (5) survives.
      @(negedge clk);
      issue(vecs[0], 1'b0);
      repeat (9) @(negedge clk);
      check("busy_in_calc", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      check("flush_result", bus.result, 32'd5);
      repeat (40) @(negedge clk);
      check("flush_result_later", bus.result, 32'd5);

      // Reset mid-CALC clears all outputs without waiting for a clock edge.
      issue(vecs[2], 1'b0);
      repeat (10) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, bus.busy}, 32'd0);
      check("arst_done", {31'd0, bus.done}, 32'd0);
      check("arst_result", bus.result, 32'd0);
      check("arst_wsel", {27'd0, bus.write_select}, 32'd0);
      check("arst_wr_en", {31'd0, bus.WR_EN}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // rd = 0: MULHU 0x80000000 x 4 = 2^33, high word 2, no write enable.
      v = '{3'b011, 32'h80000000, 32'd4, 5'd0, 32'd2};
      run_op(v);

      // start held high: second op is accepted the edge after DONE.
      v = '{3'b101, 32'd1000, 32'd10, 5'd20, 32'd100};
      @(negedge clk);
      prev = done_cnt;
      bus.funct3 = v.f3; bus.op_a = v.a; bus.op_b = v.b; bus.rd = v.rd;
      bus.start = 1'b1;
      e.res = v.res; e.ws = v.rd; e.we = 1'b1; e.start_cyc = cyc + 1;
      q.push_back(e);
      e.start_cyc = cyc + 36;
      q.push_back(e);
      repeat (36) @(negedge clk);
      bus.start = 1'b0;
      wait_done(prev + 1);
      repeat (40) @(negedge clk);
      check("done_count", 32'(done_cnt - prev), 32'd2);
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
